uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Serial receive end of the console UART link: accepts 8N1 frames on a single line, validates start and stop bits, and buffers received bytes in a FIFO.
- The FIFO is read over a valid/ready byte interface.
- Sits between the board pin and the console mux arbiter, and lets the mux stall without losing bytes.

Parameters:
- CLK_PER_BIT, 100, clk cycles per bit period; must be >= 4.
- FIFO_DEPTH, 16, byte entries; must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial line; idles high.
- rx_valid  out  1  FIFO non-empty; rx_data is valid.
- rx_data  out  8  head-of-FIFO byte, first-word-fall-through.
- rx_ready  in  1  consumer pops the head when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: good byte dropped because FIFO full.
- parity_err  out  1  one-cycle pulse; see Optional Feature.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset is synchronous, active-low, and sampled on posedge clk.
  - Asserting rst_n=0 at any point, including mid-frame, returns the FSM to ARM.
  - The FIFO is emptied.
  - Outputs reset to: rx_valid=0, rx_data=0, frame_err=0, overrun=0, parity_err=0, fifo_count=0.
  - Synchronizer flops reset to 1.
- rx passes through a 2-flop synchronizer; rxs denotes the synchronized value. The bit counter (clog2(CLK_PER_BIT) bits) and the data-bit index (3 bits) are cleared on every state entry.
- FSM states:
  - ARM: wait until rxs=1, then go to IDLE. This prevents a line held low through reset from being taken as a start bit.
  - IDLE: on rxs=0, go to START with the counter cleared.
  - START: at count CLK_PER_BIT/2-1 (mid-bit), re-check rxs. If rxs=0, go to DATA. If rxs=1, treat it as a glitch and go to IDLE with no output.
  - DATA: sample rxs every CLK_PER_BIT cycles from the start midpoint, LSB first, into a shift register. After bit 7, go to STOP (or PARITY when the macro is set).
  - STOP: sample at mid-bit.
    - rxs=1: push the byte.
    - rxs=0: pulse frame_err; the byte is dropped.
    - Either way, go to IDLE immediately after the mid-bit sample. This allows back-to-back frames with zero idle time.
- Push latency: rx_valid and rx_data appear 1 cycle after the stop mid-sample when the FIFO was empty. Total latency from the rx start edge to rx_valid is about 9.5*CLK_PER_BIT + 3 cycles.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address for full/empty detection; pointers wrap naturally.
  - Pop occurs when rx_valid && rx_ready. rx_ready while empty is ignored.
  - Push into a full FIFO is rejected: no write, overrun pulses, and the stored data is unchanged.
  - Push and pop in the same cycle when full: both occur, the push is accepted, no overrun, count unchanged.
  - Push and pop in the same cycle otherwise: count unchanged.
- frame_err and overrun are mutually exclusive per frame. A framing-errored byte never reaches the FIFO.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and samples one even-parity bit at mid-bit.
  - On mismatch, parity_err pulses one cycle (coincident with the STOP mid-sample) and the byte is dropped.
  - The frame length becomes 11 bits.
- Undefined: 8N1 only, and parity_err is tied to 0.

Decomposition:
- Shared package uart_pkg contains:
  - state enum {ARM, IDLE, START, DATA, PARITY, STOP};
  - UART_DATA_W=8;
  - default CLK_PER_BIT=100.
- One sub-module, uart_byte_fifo: synchronous FIFO with parameter DEPTH, push/pop/full/empty/count.
  - The receive FSM, synchronizer and bit timing stay in uart_rx_fifo.

Test Plan:
1. Bytes 0x00..0xFF sent back-to-back from uart_tx at CPB=16, with rx_ready=1 -> 256 bytes out in order, zero errors, fifo_count never exceeds 1.
2. rx_ready=0 and 17 frames sent with FIFO_DEPTH=16 -> fifo_count=16 and exactly 1 overrun pulse on the 17th. Then drain -> bytes 1..16 in order.
3. Frame 0xA5 with the stop bit forced low -> frame_err pulses once, no push, and the next correct frame 0x3C is received intact.
4. rx low for 5 cycles at CPB=16 (shorter than half a bit) -> no output and no error pulses; the FSM returns to IDLE.
5. rst_n=0 asserted during DATA bit 4 with rx held low across release -> no byte until rx rises. The following 0x5A is received correctly and the FIFO shows no stale entries.
6. With UART_RX_PARITY_EN, 0x07 sent with wrong parity -> parity_err pulses once and no push. With correct parity -> 0x07 is delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the console UART receive path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int UART_DATA_W          = 8;
   localparam int UART_CLK_PER_BIT_DFLT = 100;

   typedef enum logic [2:0] {
      ARM    = 3'd0,
      IDLE   = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// ============================================================================
// Module   : uart_byte_fifo
// Purpose  : First-word-fall-through synchronous FIFO; a full FIFO rejects a
//            push unless a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = UART_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign count     = r_wr_ptr - r_rd_ptr;
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign pop_data  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 8N1 UART receiver with start/stop validation and a byte FIFO.
//            Define UART_RX_PARITY_EN to add one even-parity bit per frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = UART_CLK_PER_BIT_DFLT,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx,
   output logic                          rx_valid,
   output logic [7:0]                    rx_data,
   input  logic                          rx_ready,
   output logic                          frame_err,
   output logic                          overrun,
   output logic                          parity_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int            CW        = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] c_mid_cnt = CW'(CLK_PER_BIT/2 - 1);
   localparam logic [CW-1:0] c_bit_cnt = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] c_arm_cnt = CW'(2);

   rx_state_t                  r_state;
   logic                       r_rx_meta;
   logic                       r_rxs;
   logic [CW-1:0]              r_cnt;
   logic [2:0]                 r_idx;
   logic [UART_DATA_W-1:0]     r_shift;
   logic                       r_frame_err;
   logic                       r_overrun;
   logic                       w_stop_mid;
   logic                       w_par_bad;
   logic                       w_push;
   logic                       w_full;
   logic                       w_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rxs     <= r_rx_meta;
      end
   end

   assign w_stop_mid = (r_state == STOP) && (r_cnt == c_bit_cnt);

`ifdef UART_RX_PARITY_EN
   logic r_par_bit;
   logic r_parity_err;
   assign w_par_bad  = ((^r_shift) != r_par_bit);
   assign parity_err = r_parity_err;
`else
   assign w_par_bad  = 1'b0;
   assign parity_err = 1'b0;
`endif

   assign w_push = w_stop_mid && r_rxs && !w_par_bad;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ARM;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         case (r_state)
            // Synchronizer resets high; dwell two cycles so a line held low
            // through reset is seen before arming.
            ARM: begin
               if (r_cnt != c_arm_cnt) begin
                  r_cnt <= r_cnt + CW'(1);
               end else if (r_rxs) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_idx   <= '0;
               end
            end
            IDLE: begin
               if (!r_rxs) begin
                  r_state <= START;
                  r_cnt   <= '0;
                  r_idx   <= '0;
               end
            end
            START: begin
               if (r_cnt == c_mid_cnt) begin
                  r_state <= r_rxs ? IDLE : DATA;
                  r_cnt   <= '0;
                  r_idx   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DATA: begin
               if (r_cnt == c_bit_cnt) begin
                  r_shift <= {r_rxs, r_shift[UART_DATA_W-1:1]};
                  r_cnt   <= '0;
                  if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= PARITY;
`else
                     r_state <= STOP;
`endif
                     r_idx   <= '0;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (r_cnt == c_bit_cnt) begin
                  r_par_bit <= r_rxs;
                  r_state   <= STOP;
                  r_cnt     <= '0;
                  r_idx     <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
`endif
            // Leave right after the mid-bit sample so a new start edge half
            // a bit later is caught with no idle time.
            STOP: begin
               if (w_stop_mid) begin
                  r_frame_err <= !r_rxs;
`ifdef UART_RX_PARITY_EN
                  r_parity_err <= w_par_bad;
`endif
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_idx   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= ARM;
               r_cnt   <= '0;
               r_idx   <= '0;
            end
         endcase
      end
   end

   // A full FIFO is never empty, so rx_ready alone decides whether a pop frees a slot.
   always_ff @(posedge clk) begin
      if (!rst_n) r_overrun <= 1'b0;
      else        r_overrun <= w_push && w_full && !rx_ready;
   end

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (r_shift),
      .pop       (rx_ready),
      .pop_data  (rx_data),
      .full      (w_full),
      .empty     (w_empty),
      .count     (fifo_count)
   );

   assign rx_valid  = !w_empty;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Scoreboard bench for uart_rx_fifo; honours UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 16;
   localparam int CNTW  = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            rx = 1'b1;
   logic            rx_ready = 1'b0;
   logic            rx_valid;
   logic [7:0]      rx_data;
   logic            frame_err;
   logic            overrun;
   logic            parity_err;
   logic [CNTW-1:0] fifo_count;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .CLK_PER_BIT (CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err),
      .fifo_count (fifo_count)
   );

   int         n_vec = 0;
   int         n_err = 0;
   int         n_ferr = 0;
   int         n_ovr = 0;
   int         n_perr = 0;
   int         max_cnt = 0;
   logic [7:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Output side: pop the scoreboard on every accepted byte, tally pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err)  n_ferr++;
         if (overrun)    n_ovr++;
         if (parity_err) n_perr++;
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) check_val("spurious_byte", {31'd0, rx_valid}, 32'd0);
            else                   check_val("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      tick(CPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(^d);
`endif
      send_bit(stop_b);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 40 * CPB && exp_q.size() != 0; i++) tick(1);
      check_val(tag, exp_q.size(), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, o0, p0;

      tick(4);
      check_val("rst_rx_valid",   {31'd0, rx_valid},   32'd0);
      check_val("rst_rx_data",    {24'd0, rx_data},    32'd0);
      check_val("rst_frame_err",  {31'd0, frame_err},  32'd0);
      check_val("rst_overrun",    {31'd0, overrun},    32'd0);
      check_val("rst_parity_err", {31'd0, parity_err}, 32'd0);
      check_val("rst_fifo_count", 32'(fifo_count),     32'd0);
      rst_n = 1'b1;
      tick(4);

      // All byte values back-to-back with the consumer always ready.
      rx_ready = 1'b1;
      max_cnt  = 0;
      for (int b = 0; b < 256; b++) begin
         exp_q.push_back(8'(b));
         send_frame(8'(b), 1'b1);
      end
      tick(CPB);
      wait_drain("t1_drain");
      check_val("t1_max_count", max_cnt, 32'd1);
      check_val("t1_frame_err", n_ferr, 32'd0);
      check_val("t1_overrun",   n_ovr,  32'd0);

      // Stalled consumer: 17 frames into a 16-deep FIFO.
      rx_ready = 1'b0;
      o0 = n_ovr;
      for (int i = 1; i <= 17; i++) begin
         if (i <= 16) exp_q.push_back(8'(i));
         send_frame(8'(i), 1'b1);
      end
      tick(4);
      check_val("t2_count_full", 32'(fifo_count), 32'd16);
      check_val("t2_overrun",    n_ovr - o0,      32'd1);
      check_val("t2_head",       {24'd0, rx_data}, 32'd1);
      rx_ready = 1'b1;
      wait_drain("t2_drain");
      tick(2);
      check_val("t2_count_empty", 32'(fifo_count), 32'd0);

      // Stop bit low, then a good frame.
      rx_ready = 1'b0;
      f0 = n_ferr;
      send_frame(8'hA5, 1'b0);
      rx = 1'b1;
      tick(2 * CPB);
      check_val("t3_frame_err", n_ferr - f0, 32'd1);
      check_val("t3_no_push",   32'(fifo_count), 32'd0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      tick(4);
      check_val("t3_count", 32'(fifo_count), 32'd1);
      rx_ready = 1'b1;
      wait_drain("t3_drain");

      // Short low glitch must be ignored, and the receiver must still work.
      f0 = n_ferr;
      o0 = n_ovr;
      rx = 1'b0;
      tick(5);
      rx = 1'b1;
      tick(3 * CPB);
      check_val("t4_no_byte",   {31'd0, rx_valid}, 32'd0);
      check_val("t4_frame_err", n_ferr - f0, 32'd0);
      check_val("t4_overrun",   n_ovr - o0,  32'd0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      wait_drain("t4_drain");

      // Reset in the middle of data bit 4 with the line held low.
      rx_ready = 1'b0;
      exp_q.push_back(8'h99);
      send_frame(8'h99, 1'b1);
      tick(2);
      check_val("t5_stale_present", 32'(fifo_count), 32'd1);
      rx = 1'b0;
      tick(5 * CPB + CPB / 2);
      rst_n = 1'b0;
      tick(3);
      exp_q.delete();
      rst_n = 1'b1;
      f0 = n_ferr;
      tick(3 * CPB);
      check_val("t5_count",     32'(fifo_count),   32'd0);
      check_val("t5_no_byte",   {31'd0, rx_valid}, 32'd0);
      check_val("t5_rx_data",   {24'd0, rx_data},  32'd0);
      check_val("t5_frame_err", n_ferr - f0,       32'd0);
      rx = 1'b1;
      tick(2 * CPB);
      check_val("t5_armed_idle", 32'(fifo_count), 32'd0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      tick(4);
      check_val("t5_one_entry", 32'(fifo_count), 32'd1);
      rx_ready = 1'b1;
      wait_drain("t5_drain");

`ifdef UART_RX_PARITY_EN
      // Wrong parity on 0x07, then the same byte with correct parity.
      rx_ready = 1'b0;
      p0 = n_perr;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(1'(8'h07 >> i));
      send_bit(~(^8'h07));
      send_bit(1'b1);
      tick(4);
      check_val("t6_parity_err", n_perr - p0,     32'd1);
      check_val("t6_no_push",    32'(fifo_count), 32'd0);
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1);
      tick(4);
      check_val("t6_parity_ok", n_perr - p0, 32'd1);
      rx_ready = 1'b1;
      wait_drain("t6_drain");
`else
      p0 = 0;
      check_val("t6_parity_tied", n_perr - p0, 32'd0);
`endif

      tick(4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
